// File: rtl/inst_queue_pkg.sv
// Shared pipeline types: the fetch-to-decode record, queue entry and queue depth.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 4;

    // One buffered instruction as returned by the instruction bus.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    // Record handed to the decode stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } D_type;

endpackage

// File: rtl/inst_queue_chk.sv
// Protocol checks for the instruction queue: responses need an outstanding request,
// and a push may only land in a full queue when a pop frees a slot in the same cycle.
module inst_queue_chk (
    input logic clk,
    input logic resetn,
    input logic resp_fire_i,
    input logic outst_zero_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i
);

    a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (!resetn)
        !(resp_fire_i && outst_zero_i));

    a_no_push_into_full: assert property (@(posedge clk) disable iff (!resetn)
        !(push_i && full_i && !pop_i));

endmodule

// File: rtl/iq_ram.sv
// Entry storage for the instruction queue: one write port, one asynchronous read port.
// Contents are intentionally not reset; the queue pointers decide what is valid.
module iq_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  iq_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output iq_entry_t       rdata_o
);

    iq_entry_t mem_q [DEPTH];

    // Write the returning instruction into its slot.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. Every issued ibus request owns a
// reserved slot, so a response can always be stored. After a redirect, responses
// to requests issued before it are counted in discard_q and dropped in order.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_fire,
    input  logic        resp_fire,
    input  logic [31:0] resp_pc,
    input  logic [31:0] resp_instr,
    output logic        issue_ok,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    input  logic        d_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] outst_q, outst_d;
    logic [PW-1:0] discard_q, discard_d;

    logic [PW-1:0] count_s;
    logic [PW-1:0] req_ext_s;
    logic [PW-1:0] resp_ext_s;
    logic [PW:0]   reserved_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          full_s;
    iq_entry_t     wr_entry_s;
    iq_entry_t     rd_entry_s;

    assign count_s    = tail_q - head_q;
    assign full_s     = (count_s == PW'(DEPTH));
    assign req_ext_s  = {{(PW-1){1'b0}}, req_fire};
    assign resp_ext_s = {{(PW-1){1'b0}}, resp_fire};
    assign reserved_s = {1'b0, count_s} + {1'b0, outst_q};

    assign issue_ok = (reserved_s < (PW+1)'(DEPTH));
    assign d_valid  = (count_s != {PW{1'b0}});
    assign d_pc     = rd_entry_s.pc;
    assign d_instr  = rd_entry_s.instr;

    assign wr_entry_s = '{pc: resp_pc, instr: resp_instr};

    // Classify this cycle's events: a flush suppresses both pop and push.
    always_comb begin
        drop_s = resp_fire && (discard_q != {PW{1'b0}});
        pop_s  = d_valid && d_ready && !flush;
        push_s = resp_fire && !drop_s && !flush;
    end

    // Next-state for pointers and counters.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        outst_d   = outst_q + req_ext_s - resp_ext_s;
        discard_d = discard_q;
        if (flush) begin
            head_d    = tail_q;
            discard_d = outst_q + req_ext_s - resp_ext_s;
        end else begin
            if (pop_s) begin
                head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                tail_d = tail_q;
            end
            if (drop_s) begin
                discard_d = discard_q - {{(PW-1){1'b0}}, 1'b1};
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Pointer and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q    <= {PW{1'b0}};
            tail_q    <= {PW{1'b0}};
            outst_q   <= {PW{1'b0}};
            discard_q <= {PW{1'b0}};
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    iq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_s && resetn),
        .waddr_i (tail_q[AW-1:0]),
        .wdata_i (wr_entry_s),
        .raddr_i (head_q[AW-1:0]),
        .rdata_o (rd_entry_s)
    );

    inst_queue_chk u_chk (
        .clk          (clk),
        .resetn       (resetn),
        .resp_fire_i  (resp_fire),
        .outst_zero_i (outst_q == {PW{1'b0}}),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .full_i       (full_s)
    );

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port flush, input, 1 bit: redirect from a later stage; discard all queued and in-flight instructions.
REQ-005 SHALL have port req_fire, input, 1 bit: fetch ibus address handshake (ireq.valid & addr_ok) this cycle.
REQ-006 SHALL have port resp_fire, input, 1 bit: ibus data_ok this cycle.
REQ-007 SHALL have port resp_pc, input, 32 bits: PC of the returning instruction.
REQ-008 SHALL have port resp_instr, input, 32 bits: returning instruction word.
REQ-009 SHALL have port issue_ok, output, 1 bit: fetch may present a new ibus request.
REQ-010 SHALL have port d_valid, output, 1 bit: head entry valid toward decode.
REQ-011 SHALL have port d_pc, output, 32 bits: head entry PC.
REQ-012 SHALL have port d_instr, output, 32 bits: head entry instruction.
REQ-013 SHALL have port d_ready, input, 1 bit: decode consumes head this cycle when d_valid is high.

Function
REQ-014 SHALL be a circular FIFO with head and tail pointers of log2(DEPTH)+1 bits; the extra wrap bit distinguishes full from empty.
REQ-015 SHALL keep an outstanding counter (0..DEPTH): +1 on req_fire, -1 on resp_fire, both in one cycle giving net 0.
REQ-016 SHALL drive issue_ok = (count + outstanding) < DEPTH, from registered state only, so every issued request owns a reserved slot.
REQ-017 SHALL keep a discard counter; resp_fire with discard>0 drops the response and decrements discard; otherwise it writes {resp_pc, resp_instr} at tail and advances tail.
REQ-018 SHALL drive d_valid = (count != 0), with d_pc/d_instr from head combinationally; head advances on d_valid & d_ready.
REQ-019 SHALL support a push and a pop in the same cycle, leaving count unchanged; push and pop at wrap-around SHALL behave identically to the non-wrap case.
REQ-020 SHALL on flush set head = tail and count = 0 next cycle, ignore any pop in that cycle, drop any resp_fire in that cycle, and load discard with outstanding + req_fire - resp_fire.
REQ-021 SHALL NOT cancel or delay the discarding of old responses when new requests issue after a flush; only old responses are dropped, in order.
REQ-022 SHALL treat resp_fire with outstanding == 0, or a push into a full queue, as illegal (simulation assertion; no recovery defined).

Reset
REQ-023 SHALL on resetn == 0 clear head, tail, outstanding and discard; next cycle d_valid = 0 and issue_ok = 1.
REQ-024 SHALL have reset override flush, req_fire and resp_fire in the same cycle; reset mid-operation drops all contents, with the ibus reset in the same cycle.
REQ-025 SHALL leave storage contents unreset; d_pc/d_instr are don't-care while d_valid = 0.

Structure
REQ-026 SHALL take the entry typedef {pc, instr} and the IQ_DEPTH constant from the shared pipeline package, next to D_type.
REQ-027 SHALL place the entry array in one sub-module, iq_ram: one write port and one asynchronous read port; pointers and counters stay in inst_queue.

Verification
REQ-028 Scenario: reset, then 4 req_fire with d_ready = 0 -> issue_ok = 0 after the 4th; 4 responses fill the queue; d_valid = 1, d_pc = first resp_pc.
REQ-029 Scenario: steady state, 1 req_fire + 1 resp_fire + pop per cycle for 20 cycles -> d_pc sequence 0xBFC00000, +4, ... in order, with no gaps across pointer wrap.
REQ-030 Scenario: 2 entries queued, 2 outstanding, flush -> next cycle d_valid = 0; the next 2 resp_fire are dropped; the 3rd response (new PC 0x80000000) appears at d_pc.
REQ-031 Scenario: flush in the same cycle as resp_fire and req_fire with outstanding = 1 -> that response is dropped and discard = 1.
REQ-032 Scenario: full queue with simultaneous pop and resp_fire -> count stays 4 and order is preserved.
REQ-033 Scenario: resetn low during a full queue with 2 outstanding -> next cycle d_valid = 0 and issue_ok = 1.
